// File: rtl/base_ram_arbiter_if.sv
// CPU-side bus of the BaseRAM arbiter: instruction-fetch port, data port and pipeline stall.
// The master modport is the CPU core; the slave modport is the arbiter.
interface base_ram_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be_n;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_o;

  modport master (
    output if_req, if_addr, mem_req, mem_wr, mem_addr, mem_wdata, mem_be_n,
    input  if_rdata, if_ack, mem_rdata, mem_ack, stall_o
  );

  modport slave (
    input  if_req, if_addr, mem_req, mem_wr, mem_addr, mem_wdata, mem_be_n,
    output if_rdata, if_ack, mem_rdata, mem_ack, stall_o
  );
endinterface

// File: rtl/base_ram_arbiter.sv
// Shares the BaseRAM SRAM between instruction fetch and data access, one latched transaction at a time.
// SRAM strobes are a registered stage behind the FSM state, so every pin changes only on clk_50M.
module base_ram_arbiter_chk (
  input logic        clk_50M,
  input logic        rst,
  input logic        if_req,
  input logic        if_ack,
  input logic [31:0] if_addr,
  input logic        mem_req,
  input logic        mem_ack,
  input logic        mem_wr,
  input logic [31:0] mem_addr,
  input logic [31:0] mem_wdata,
  input logic [3:0]  mem_be_n,
  input logic        ce_n,
  input logic        oe_n,
  input logic        we_n,
  input logic        data_oe
);
  a_no_oe_we_overlap: assert property (@(posedge clk_50M) disable iff (rst) !(!oe_n && !we_n));
  a_no_drive_on_read: assert property (@(posedge clk_50M) disable iff (rst) !oe_n |-> !data_oe);
  a_oe_needs_ce:      assert property (@(posedge clk_50M) disable iff (rst) !oe_n |-> !ce_n);
  a_single_owner_ack: assert property (@(posedge clk_50M) disable iff (rst) !(if_ack && mem_ack));
  a_if_ack_pulse:     assert property (@(posedge clk_50M) disable iff (rst) if_ack |=> !if_ack);
  a_mem_ack_pulse:    assert property (@(posedge clk_50M) disable iff (rst) mem_ack |=> !mem_ack);
  a_if_aligned:       assert property (@(posedge clk_50M) disable iff (rst)
                                       if_req |-> (if_addr[1:0] == 2'b00 && !$isunknown(if_addr)));
  a_mem_known:        assert property (@(posedge clk_50M) disable iff (rst)
                                       mem_req |-> !$isunknown({mem_wr, mem_addr, mem_wdata, mem_be_n}));
endmodule

module base_ram_arbiter #(
  parameter int READ_CYCLES = 2,
  parameter int WE_CYCLES   = 2
) (
  input  logic                  clk_50M,
  input  logic                  rst,
  base_ram_arbiter_if.slave     bus,
  input  logic [31:0]           base_ram_data_i,
  output logic [31:0]           base_ram_data_o,
  output logic                  base_ram_data_oe,
  output logic [19:0]           base_ram_addr,
  output logic [3:0]            base_ram_be_n,
  output logic                  base_ram_ce_n,
  output logic                  base_ram_oe_n,
  output logic                  base_ram_we_n
);
  localparam int MAX_CYC = (READ_CYCLES > WE_CYCLES) ? READ_CYCLES : WE_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_CYCLES - 1);
  localparam logic [CNT_W-1:0] WE_LAST = CNT_W'(WE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4
  } state_t;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } grant_t;

  state_t            state_r;
  state_t            state_s;
  logic [CNT_W-1:0]  cnt_r;
  grant_t            last_grant_r;
  grant_t            owner_r;
  logic              wr_r;
  logic [3:0]        be_lat_r;
  logic [19:0]       addr_r;
  logic [31:0]       wdata_r;
  logic              done_r;
  logic              done_s;
  logic              grant_s;
  logic              grant_mem_s;
  logic              sample_ok_s;
  logic              if_ack_r;
  logic              mem_ack_r;
  logic [31:0]       if_rdata_r;
  logic [31:0]       mem_rdata_r;
  logic              ce_n_r;
  logic              oe_n_r;
  logic              we_n_r;
  logic              data_oe_r;
  logic [3:0]        be_n_r;

  // A completing transaction blocks new grants until its ack cycle is over.
  assign sample_ok_s = ~if_ack_r & ~mem_ack_r & ~done_r;

  // Next-state, grant and completion decode.
  always_comb begin
    state_s     = state_r;
    grant_s     = 1'b0;
    grant_mem_s = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sample_ok_s && (bus.if_req || bus.mem_req)) begin
          grant_s = 1'b1;
          if (bus.mem_req && (!bus.if_req || (last_grant_r == GNT_IF))) begin
            grant_mem_s = 1'b1;
            if (bus.mem_wr) begin
              state_s = ST_WR_SETUP;
            end else begin
              state_s = ST_READ;
            end
          end else begin
            grant_mem_s = 1'b0;
            state_s     = ST_READ;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (cnt_r == RD_LAST) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_WR_SETUP: begin
        state_s = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        if (cnt_r == WE_LAST) begin
          state_s = ST_WR_HOLD;
        end else begin
          state_s = ST_WR_PULSE;
        end
      end
      ST_WR_HOLD: begin
        state_s = ST_IDLE;
        done_s  = 1'b1;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register; the cycle counter restarts on every state change.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= (state_s != state_r) ? '0 : cnt_r + CNT_W'(1);
    end
  end

  // Latch the granted request; the address bus holds its value between transactions.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      last_grant_r <= GNT_IF;
      owner_r      <= GNT_IF;
      wr_r         <= 1'b0;
      be_lat_r     <= 4'b0000;
      addr_r       <= 20'h00000;
      wdata_r      <= 32'h0000_0000;
    end else if (grant_s) begin
      if (grant_mem_s) begin
        last_grant_r <= GNT_MEM;
        owner_r      <= GNT_MEM;
        wr_r         <= bus.mem_wr;
        be_lat_r     <= bus.mem_be_n;
        addr_r       <= bus.mem_addr[21:2];
        wdata_r      <= bus.mem_wdata;
      end else begin
        last_grant_r <= GNT_IF;
        owner_r      <= GNT_IF;
        wr_r         <= 1'b0;
        be_lat_r     <= 4'b0000;
        addr_r       <= bus.if_addr[21:2];
      end
    end
  end

  // SRAM strobe stage, one register behind the FSM state.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      ce_n_r    <= 1'b1;
      oe_n_r    <= 1'b1;
      we_n_r    <= 1'b1;
      data_oe_r <= 1'b0;
      be_n_r    <= 4'b1111;
    end else begin
      case (state_r)
        ST_READ: begin
          ce_n_r    <= 1'b0;
          oe_n_r    <= 1'b0;
          we_n_r    <= 1'b1;
          data_oe_r <= 1'b0;
          be_n_r    <= be_lat_r;
        end
        ST_WR_SETUP, ST_WR_HOLD: begin
          ce_n_r    <= 1'b0;
          oe_n_r    <= 1'b1;
          we_n_r    <= 1'b1;
          data_oe_r <= 1'b1;
          be_n_r    <= be_lat_r;
        end
        ST_WR_PULSE: begin
          ce_n_r    <= 1'b0;
          oe_n_r    <= 1'b1;
          we_n_r    <= 1'b0;
          data_oe_r <= 1'b1;
          be_n_r    <= be_lat_r;
        end
        default: begin
          ce_n_r    <= 1'b1;
          oe_n_r    <= 1'b1;
          we_n_r    <= 1'b1;
          data_oe_r <= 1'b0;
          be_n_r    <= 4'b1111;
        end
      endcase
    end
  end

  // Completion: capture read data while oe_n is still low and pulse the owner's ack.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      done_r      <= 1'b0;
      if_ack_r    <= 1'b0;
      mem_ack_r   <= 1'b0;
      if_rdata_r  <= 32'h0000_0000;
      mem_rdata_r <= 32'h0000_0000;
    end else begin
      done_r    <= done_s;
      if_ack_r  <= done_r && (owner_r == GNT_IF);
      mem_ack_r <= done_r && (owner_r == GNT_MEM);
      if (done_r && !wr_r && (owner_r == GNT_IF)) begin
        if_rdata_r <= base_ram_data_i;
      end
      if (done_r && !wr_r && (owner_r == GNT_MEM)) begin
        mem_rdata_r <= base_ram_data_i;
      end
    end
  end

  assign bus.if_rdata  = if_rdata_r;
  assign bus.if_ack    = if_ack_r;
  assign bus.mem_rdata = mem_rdata_r;
  assign bus.mem_ack   = mem_ack_r;
  assign bus.stall_o   = (bus.if_req & ~if_ack_r) | (bus.mem_req & ~mem_ack_r);

  assign base_ram_data_o  = wdata_r;
  assign base_ram_data_oe = data_oe_r;
  assign base_ram_addr    = addr_r;
  assign base_ram_be_n    = be_n_r;
  assign base_ram_ce_n    = ce_n_r;
  assign base_ram_oe_n    = oe_n_r;
  assign base_ram_we_n    = we_n_r;

  base_ram_arbiter_chk u_chk (
    .clk_50M   (clk_50M),
    .rst       (rst),
    .if_req    (bus.if_req),
    .if_ack    (if_ack_r),
    .if_addr   (bus.if_addr),
    .mem_req   (bus.mem_req),
    .mem_ack   (mem_ack_r),
    .mem_wr    (bus.mem_wr),
    .mem_addr  (bus.mem_addr),
    .mem_wdata (bus.mem_wdata),
    .mem_be_n  (bus.mem_be_n),
    .ce_n      (ce_n_r),
    .oe_n      (oe_n_r),
    .we_n      (we_n_r),
    .data_oe   (data_oe_r)
  );
endmodule

// File: tb/tb_base_ram_arbiter.sv
// Directed bench for base_ram_arbiter with a byte-lane SRAM model and strobe/ack counters.
module tb_base_ram_arbiter;
  logic        clk_50M;
  logic        rst;
  logic [31:0] ram_data_i;
  logic [31:0] ram_data_o;
  logic        ram_data_oe;
  logic [19:0] ram_addr;
  logic [3:0]  ram_be_n;
  logic        ram_ce_n;
  logic        ram_oe_n;
  logic        ram_we_n;
  logic [31:0] sram [0:255];

  int errors = 0;
  int checks = 0;
  int oe_low_cnt = 0;
  int we_low_cnt = 0;
  int doe_cnt = 0;
  int if_ack_cnt = 0;
  int mem_ack_cnt = 0;

  base_ram_arbiter_if bus ();

  base_ram_arbiter #(.READ_CYCLES(2), .WE_CYCLES(2)) dut (
    .clk_50M          (clk_50M),
    .rst              (rst),
    .bus              (bus),
    .base_ram_data_i  (ram_data_i),
    .base_ram_data_o  (ram_data_o),
    .base_ram_data_oe (ram_data_oe),
    .base_ram_addr    (ram_addr),
    .base_ram_be_n    (ram_be_n),
    .base_ram_ce_n    (ram_ce_n),
    .base_ram_oe_n    (ram_oe_n),
    .base_ram_we_n    (ram_we_n)
  );

  initial clk_50M = 1'b0;
  always #10 clk_50M = ~clk_50M;

  // Asynchronous SRAM: reads combinationally, writes enabled byte lanes while we_n is low.
  assign ram_data_i = (!ram_ce_n && !ram_oe_n) ? sram[ram_addr[7:0]] : 32'h0000_0000;
  always @(posedge clk_50M) begin
    if (!ram_ce_n && !ram_we_n && ram_data_oe) begin
      for (int b = 0; b < 4; b++) begin
        if (!ram_be_n[b]) sram[ram_addr[7:0]][b*8 +: 8] <= ram_data_o[b*8 +: 8];
      end
    end
  end

  always @(negedge clk_50M) begin
    if (!ram_oe_n) oe_low_cnt++;
    if (!ram_we_n) we_low_cnt++;
    if (ram_data_oe) doe_cnt++;
    if (bus.if_ack) if_ack_cnt++;
    if (bus.mem_ack) mem_ack_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request, measure ack latency from the grant edge, check stall_o, then release.
  task automatic run_txn(input bit is_mem, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be_n, input bit hold,
                         input int exp_lat, input string tag);
    int  lat;
    bit  seen;
    bit  stall_bad;
    lat = 0; seen = 1'b0; stall_bad = 1'b0;
    @(negedge clk_50M);
    if (is_mem) begin
      bus.mem_wr = wr; bus.mem_addr = addr; bus.mem_wdata = wdata; bus.mem_be_n = be_n;
      bus.mem_req = 1'b1;
    end else begin
      bus.if_addr = addr;
      bus.if_req  = 1'b1;
    end
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk_50M);
      if ((is_mem && bus.mem_ack) || (!is_mem && bus.if_ack)) begin
        seen = 1'b1;
        lat  = k - 1;
      end else if (!bus.stall_o) begin
        stall_bad = 1'b1;
      end
    end
    chk({tag, " ack latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " stall before ack"}, {31'd0, stall_bad}, 32'd0);
    chk({tag, " stall in ack cycle"}, {31'd0, bus.stall_o}, 32'd0);
    if (hold) @(negedge clk_50M);
    bus.if_req  = 1'b0;
    bus.mem_req = 1'b0;
    @(negedge clk_50M);
    chk({tag, " ack single pulse"}, {30'd0, bus.if_ack, bus.mem_ack}, 32'd0);
  endtask

  int      s_oe, s_we, s_doe, s_if, s_mem;
  int      nacks;
  bit      seen5, overlap, dbl, prev_if, prev_mem, raise_if, raise_mem;
  logic [3:0] order;

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = 32'h0000_0000;
    sram[4] = 32'h3C1A_8000;
    sram[5] = 32'h1111_2222;
    bus.if_req = 1'b0; bus.if_addr = 32'h8000_0000;
    bus.mem_req = 1'b0; bus.mem_wr = 1'b0; bus.mem_addr = 32'h8000_0000;
    bus.mem_wdata = 32'h0000_0000; bus.mem_be_n = 4'b1111;
    rst = 1'b1;
    repeat (3) @(posedge clk_50M);
    @(negedge clk_50M);
    chk("reset strobes ce/oe/we/oe_drv", {28'd0, ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe}, 32'h0000_000E);
    chk("reset be_n", {28'd0, ram_be_n}, 32'h0000_000F);
    chk("reset addr", {12'd0, ram_addr}, 32'h0000_0000);
    chk("reset data_o", ram_data_o, 32'h0000_0000);
    chk("reset acks/stall", {29'd0, bus.if_ack, bus.mem_ack, bus.stall_o}, 32'd0);
    chk("reset if_rdata", bus.if_rdata, 32'h0000_0000);
    chk("reset mem_rdata", bus.mem_rdata, 32'h0000_0000);
    rst = 1'b0;

    // 1: instruction fetch
    s_oe = oe_low_cnt; s_we = we_low_cnt;
    run_txn(1'b0, 1'b0, 32'h8000_0010, 32'h0, 4'b0000, 1'b0, 3, "t1 if read");
    chk("t1 sram word addr", {12'd0, ram_addr}, 32'h0000_0004);
    chk("t1 oe_n low cycles", 32'(oe_low_cnt - s_oe), 32'd2);
    chk("t1 we_n low cycles", 32'(we_low_cnt - s_we), 32'd0);
    chk("t1 if_rdata", bus.if_rdata, 32'h3C1A_8000);

    // 2: full-word write
    s_oe = oe_low_cnt; s_we = we_low_cnt; s_doe = doe_cnt;
    run_txn(1'b1, 1'b1, 32'h8000_0020, 32'hDEAD_BEEF, 4'b0000, 1'b0, 5, "t2 mem write");
    chk("t2 we_n low cycles", 32'(we_low_cnt - s_we), 32'd2);
    chk("t2 data_oe cycles", 32'(doe_cnt - s_doe), 32'd4);
    chk("t2 oe_n low cycles", 32'(oe_low_cnt - s_oe), 32'd0);
    chk("t2 sram word 8", sram[8], 32'hDEAD_BEEF);

    // 3: byte-lane write then raw read-back
    run_txn(1'b1, 1'b1, 32'h8000_0020, 32'h0000_00AB, 4'b1110, 1'b0, 5, "t3 byte write");
    chk("t3 be_n released", {28'd0, ram_be_n}, 32'h0000_000F);
    run_txn(1'b1, 1'b0, 32'h8000_0020, 32'h0, 4'b0000, 1'b0, 3, "t3 mem read");
    chk("t3 mem_rdata", bus.mem_rdata, 32'hDEAD_BEAB);

    // 6: requester holds req through its ack cycle (also leaves last grant = IF)
    s_oe = oe_low_cnt; s_if = if_ack_cnt;
    run_txn(1'b0, 1'b0, 32'h8000_0010, 32'h0, 4'b0000, 1'b1, 3, "t6 held req");
    repeat (6) @(negedge clk_50M);
    chk("t6 if_ack count", 32'(if_ack_cnt - s_if), 32'd1);
    chk("t6 oe_n low cycles", 32'(oe_low_cnt - s_oe), 32'd2);

    // 4: both ports held, alternating grants
    bus.if_addr = 32'h8000_0014; bus.mem_wr = 1'b0; bus.mem_addr = 32'h8000_0020; bus.mem_be_n = 4'b0000;
    @(negedge clk_50M);
    bus.if_req = 1'b1; bus.mem_req = 1'b1;
    order = 4'b0000; nacks = 0; overlap = 1'b0; dbl = 1'b0;
    prev_if = 1'b0; prev_mem = 1'b0; raise_if = 1'b0; raise_mem = 1'b0;
    for (int c = 0; c < 100 && nacks < 4; c++) begin
      @(negedge clk_50M);
      if (raise_if) begin bus.if_req = 1'b1; raise_if = 1'b0; end
      if (raise_mem) begin bus.mem_req = 1'b1; raise_mem = 1'b0; end
      if (bus.if_ack && bus.mem_ack) overlap = 1'b1;
      if ((bus.if_ack && prev_if) || (bus.mem_ack && prev_mem)) dbl = 1'b1;
      if (bus.mem_ack) begin
        order = {order[2:0], 1'b1}; nacks++;
        bus.mem_req = 1'b0; raise_mem = 1'b1;
        chk("t4 mem_rdata", bus.mem_rdata, 32'hDEAD_BEAB);
      end else if (bus.if_ack) begin
        order = {order[2:0], 1'b0}; nacks++;
        bus.if_req = 1'b0; raise_if = 1'b1;
        chk("t4 if_rdata", bus.if_rdata, 32'h1111_2222);
      end
      prev_if = bus.if_ack; prev_mem = bus.mem_ack;
    end
    bus.if_req = 1'b0; bus.mem_req = 1'b0;
    chk("t4 ack count", 32'(nacks), 32'd4);
    chk("t4 grant order (1=MEM)", {28'd0, order}, 32'h0000_000A);
    chk("t4 ack overlap", {31'd0, overlap}, 32'd0);
    chk("t4 ack multi-cycle", {31'd0, dbl}, 32'd0);
    repeat (3) @(negedge clk_50M);

    // 5: reset during the write pulse
    @(negedge clk_50M);
    bus.mem_wr = 1'b1; bus.mem_addr = 32'h8000_0030; bus.mem_wdata = 32'h1234_5678; bus.mem_be_n = 4'b0000;
    bus.mem_req = 1'b1;
    seen5 = 1'b0;
    for (int k = 0; k < 20 && !seen5; k++) begin
      @(negedge clk_50M);
      if (!ram_we_n) seen5 = 1'b1;
    end
    chk("t5 reached write pulse", {31'd0, seen5}, 32'd1);
    s_mem = mem_ack_cnt;
    rst = 1'b1;
    @(negedge clk_50M);
    chk("t5 strobes after reset", {28'd0, ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe}, 32'h0000_000E);
    chk("t5 be_n after reset", {28'd0, ram_be_n}, 32'h0000_000F);
    chk("t5 addr after reset", {12'd0, ram_addr}, 32'h0000_0000);
    rst = 1'b0;
    bus.mem_req = 1'b0;
    repeat (6) @(negedge clk_50M);
    chk("t5 no mem_ack", 32'(mem_ack_cnt - s_mem), 32'd0);
    chk("t5 idle strobes", {28'd0, ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe}, 32'h0000_000E);
    run_txn(1'b0, 1'b0, 32'h8000_0010, 32'h0, 4'b0000, 1'b0, 3, "t5 post-reset read");
    chk("t5 post-reset if_rdata", bus.if_rdata, 32'h3C1A_8000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
